cmp_window_tracker: RTL and testbench

- Streaming stage directly downstream of the 4-bit magnitude comparator.
- Accepts unsigned samples over a valid/ready handshake and applies the comparator's three-way relation, less / equal / greater, to each sample against the previous sample and against the running extremes.
- After every window of WIN samples, presents a registered result over a valid/ready handshake: max, min, index of first max, and counts of up / flat / down steps.
- Feeds the status/report logic downstream.

---
 rtl/cmp_window_tracker.sv | 202 ++++++++++++++++++++
 tb/tb_cmp_window_tracker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_window_tracker.sv
// -----------------------------------------------------------------------------
// cmp_window_tracker
//
// Streaming stage that follows the 4-bit magnitude comparator. Each accepted
// sample is classified against its predecessor (up / flat / down) and against
// the running extremes of the current window. After WIN samples the window
// summary is registered and offered downstream over a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     in_data carries a sample
//   in_ready     block can accept a sample (low while rst is high and in DONE)
//   in_data      unsigned sample, WIDTH bits
//   out_valid    window result is valid
//   out_ready    consumer takes the result
//   out_max      largest sample of the window
//   out_min      smallest sample of the window
//   out_max_idx  0-based position of the first occurrence of out_max
//   out_up       samples greater than their predecessor
//   out_flat     samples equal to their predecessor
//   out_down     samples less than their predecessor
// -----------------------------------------------------------------------------
module cmp_window_tracker #(
  parameter int WIDTH = 4,
  parameter int WIN   = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_up,
  output logic [CNT_W-1:0] out_flat,
  output logic [CNT_W-1:0] out_down
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  // Position of the last sample of a window; reaching it closes the window.
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIN - 1);

  state_t           state_reg, state_next;

  // Running window state
  logic [WIDTH-1:0] prev_reg, prev_next;
  logic [WIDTH-1:0] max_reg, max_next;
  logic [WIDTH-1:0] min_reg, min_next;
  logic [CNT_W-1:0] max_idx_reg, max_idx_next;
  logic [CNT_W-1:0] up_reg, up_next;
  logic [CNT_W-1:0] flat_reg, flat_next;
  logic [CNT_W-1:0] down_reg, down_next;
  logic [CNT_W-1:0] pos_reg, pos_next;

  // Registered window result
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_max_reg, out_max_next;
  logic [WIDTH-1:0] out_min_reg, out_min_next;
  logic [CNT_W-1:0] out_max_idx_reg, out_max_idx_next;
  logic [CNT_W-1:0] out_up_reg, out_up_next;
  logic [CNT_W-1:0] out_flat_reg, out_flat_next;
  logic [CNT_W-1:0] out_down_reg, out_down_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      prev_reg        <= '0;
      max_reg         <= '0;
      min_reg         <= '0;
      max_idx_reg     <= '0;
      up_reg          <= '0;
      flat_reg        <= '0;
      down_reg        <= '0;
      pos_reg         <= '0;
      out_valid_reg   <= 1'b0;
      out_max_reg     <= '0;
      out_min_reg     <= '0;
      out_max_idx_reg <= '0;
      out_up_reg      <= '0;
      out_flat_reg    <= '0;
      out_down_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      prev_reg        <= prev_next;
      max_reg         <= max_next;
      min_reg         <= min_next;
      max_idx_reg     <= max_idx_next;
      up_reg          <= up_next;
      flat_reg        <= flat_next;
      down_reg        <= down_next;
      pos_reg         <= pos_next;
      out_valid_reg   <= out_valid_next;
      out_max_reg     <= out_max_next;
      out_min_reg     <= out_min_next;
      out_max_idx_reg <= out_max_idx_next;
      out_up_reg      <= out_up_next;
      out_flat_reg    <= out_flat_next;
      out_down_reg    <= out_down_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    prev_next        = prev_reg;
    max_next         = max_reg;
    min_next         = min_reg;
    max_idx_next     = max_idx_reg;
    up_next          = up_reg;
    flat_next        = flat_reg;
    down_next        = down_reg;
    pos_next         = pos_reg;
    out_valid_next   = out_valid_reg;
    out_max_next     = out_max_reg;
    out_min_next     = out_min_reg;
    out_max_idx_next = out_max_idx_reg;
    out_up_next      = out_up_reg;
    out_flat_next    = out_flat_reg;
    out_down_next    = out_down_reg;
    in_ready         = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // First sample seeds every running value; it has no predecessor.
          prev_next    = in_data;
          max_next     = in_data;
          min_next     = in_data;
          max_idx_next = '0;
          up_next      = '0;
          flat_next    = '0;
          down_next    = '0;
          pos_next     = CNT_W'(1);
          state_next   = ACC;
        end
      end

      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data > prev_reg)
            up_next = up_reg + CNT_W'(1);
          else if (in_data == prev_reg)
            flat_next = flat_reg + CNT_W'(1);
          else
            down_next = down_reg + CNT_W'(1);

          // Strict compares so a tie keeps the earlier max position.
          if (in_data > max_reg) begin
            max_next     = in_data;
            max_idx_next = pos_reg;
          end
          if (in_data < min_reg)
            min_next = in_data;

          prev_next = in_data;
          pos_next  = pos_reg + CNT_W'(1);

          // Closing sample: publish the values that include this sample.
          if (pos_reg == LAST_POS) begin
            out_max_next     = max_next;
            out_min_next     = min_next;
            out_max_idx_next = max_idx_next;
            out_up_next      = up_next;
            out_flat_next    = flat_next;
            out_down_next    = down_next;
            out_valid_next   = 1'b1;
            state_next       = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // Nothing is taken while reset is held.
    if (rst)
      in_ready = 1'b0;
  end

  assign out_valid   = out_valid_reg;
  assign out_max     = out_max_reg;
  assign out_min     = out_min_reg;
  assign out_max_idx = out_max_idx_reg;
  assign out_up      = out_up_reg;
  assign out_flat    = out_flat_reg;
  assign out_down    = out_down_reg;

endmodule

// File: tb/tb_cmp_window_tracker.sv
module tb_cmp_window_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [3:0] out_min;
  logic [3:0] out_max_idx;
  logic [3:0] out_up;
  logic [3:0] out_flat;
  logic [3:0] out_down;

  int tests = 0;
  int fails = 0;

  cmp_window_tracker #(.WIDTH(4), .WIN(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_min     (out_min),
    .out_max_idx (out_max_idx),
    .out_up      (out_up),
    .out_flat    (out_flat),
    .out_down    (out_down)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample and hold it until it is accepted; returns at posedge+1.
  task automatic send(input logic [3:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Idle cycles with junk on in_data; none of it may be taken.
  task automatic gap();
    int unsigned n;
    n = $urandom_range(0, 3);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic send_window(input logic [3:0] s [8], input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) gap();
      send(s[i]);
    end
  endtask

  // Wait for the window result and compare every field. With out_ready high
  // also confirm the handshake clears out_valid and reopens in_ready.
  task automatic expect_result(input string tag, input int mx, input int mn, input int idx,
                               input int up, input int flat, input int down);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"},   32'(out_valid),   32'd1);
    check({tag, "_max"},     32'(out_max),     32'(mx));
    check({tag, "_min"},     32'(out_min),     32'(mn));
    check({tag, "_max_idx"}, 32'(out_max_idx), 32'(idx));
    check({tag, "_up"},      32'(out_up),      32'(up));
    check({tag, "_flat"},    32'(out_flat),    32'(flat));
    check({tag, "_down"},    32'(out_down),    32'(down));
    check({tag, "_sum"},     32'(out_up) + 32'(out_flat) + 32'(out_down), 32'd7);
    check({tag, "_inrdy_done"}, 32'(in_ready), 32'd0);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_inrdy_back"}, 32'(in_ready),  32'd1);
      check({tag, "_max_kept"},   32'(out_max),   32'(mx));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] w [8];

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),    32'd0);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_out_max",   32'(out_max),     32'd0);
    check("rst_out_min",   32'(out_min),     32'd0);
    check("rst_out_idx",   32'(out_max_idx), 32'd0);
    check("rst_counts",    32'({out_up, out_flat, out_down}), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Ascending with a final drop
    w = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd6};
    send_window(w, 1'b0);
    expect_result("asc", 7, 0, 6, 6, 0, 1);

    // All equal at full scale
    w = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    send_window(w, 1'b0);
    expect_result("eq", 15, 15, 0, 0, 7, 0);

    // Descending with ties
    w = '{4'd15, 4'd15, 4'd12, 4'd10, 4'd10, 4'd9, 4'd8, 4'd8};
    send_window(w, 1'b0);
    expect_result("desc", 15, 8, 0, 0, 3, 4);

    // Backpressure: result held while out_ready stays low
    out_ready = 1'b0;
    w = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6};
    send_window(w, 1'b0);
    expect_result("bp", 9, 1, 5, 4, 0, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 4'($urandom_range(0, 15));
      #1;
      check("bp_hold_valid", 32'(out_valid),   32'd1);
      check("bp_hold_inrdy", 32'(in_ready),    32'd0);
      check("bp_hold_max",   32'(out_max),     32'd9);
      check("bp_hold_idx",   32'(out_max_idx), 32'd5);
      check("bp_hold_up",    32'(out_up),      32'd4);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_inrdy", 32'(in_ready),  32'd1);
    check("bp_release_max",   32'(out_max),   32'd9);
    check("bp_release_down",  32'(out_down),  32'd3);

    // Reset mid-window discards the partial window and clears outputs
    send(4'd9);
    send(4'd10);
    send(4'd11);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(out_valid),   32'd0);
    check("mid_rst_inrdy", 32'(in_ready),    32'd0);
    check("mid_rst_max",   32'(out_max),     32'd0);
    check("mid_rst_min",   32'(out_min),     32'd0);
    check("mid_rst_idx",   32'(out_max_idx), 32'd0);
    check("mid_rst_cnts",  32'({out_up, out_flat, out_down}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    w = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
    send_window(w, 1'b0);
    expect_result("after_rst", 2, 1, 1, 4, 0, 3);

    // Back-to-back windows with random input gaps
    w = '{4'd5, 4'd5, 4'd6, 4'd2, 4'd2, 4'd2, 4'd8, 4'd0};
    send_window(w, 1'b1);
    expect_result("gapA", 8, 0, 6, 2, 3, 2);
    w = '{4'd7, 4'd3, 4'd3, 4'd9, 4'd12, 4'd1, 4'd4, 4'd4};
    send_window(w, 1'b1);
    expect_result("gapB", 12, 1, 4, 3, 2, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
